seven_seg_scan_driver: RTL and testbench

- Parametrised, time-multiplexed driver for N common-anode 7-segment digits sharing one segment bus.
- Accepts a packed hex/BCD word and per-digit decimal points, and double-buffers them so that frame updates are tear-free.
- Scans the digits with a programmable dwell time and anti-ghosting dead time, with optional leading-zero suppression.
- Sits between the datapath (counters, ALU results) and the board's display pins.

---
 rtl/seven_seg_scan_driver.sv | 129 ++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for N common-anode 7-segment digits on a shared, active-low segment bus.
// A pending/active double buffer makes frame updates tear-free.
module seven_seg_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYC    = 2,
    parameter int HEX_EN      = 1,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] pend_val, act_val, act_val_nxt;
    logic [N_DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
    logic [N_DIGITS-1:0]   lz_mask;
    logic [N_DIGITS-1:0]   an_nxt;
    logic [6:0]            seg_nxt;
    logic [3:0]            code;
    logic                  frame_start, lz_hit, dp_bit, all_zero;

    function automatic logic [6:0] seg_lut(input logic [3:0] c);
        case (c)
            4'h0: seg_lut = 7'b0000001;
            4'h1: seg_lut = 7'b1001111;
            4'h2: seg_lut = 7'b0010010;
            4'h3: seg_lut = 7'b0000110;
            4'h4: seg_lut = 7'b1001100;
            4'h5: seg_lut = 7'b0100100;
            4'h6: seg_lut = 7'b0100000;
            4'h7: seg_lut = 7'b0001111;
            4'h8: seg_lut = 7'b0000000;
            4'h9: seg_lut = 7'b0000100;
            4'hA: seg_lut = 7'b0001000;
            4'hB: seg_lut = 7'b1100000;
            4'hC: seg_lut = 7'b0110001;
            4'hD: seg_lut = 7'b1000010;
            4'hE: seg_lut = 7'b0110000;
            default: seg_lut = 7'b0111000;
        endcase
    endfunction

    // Index is held at 0 while disabled, so the first enabled cycle is also a frame start.
    assign frame_start = enable && (pre == '0) && (idx == '0);
    assign act_val_nxt = frame_start ? (load ? value : pend_val) : act_val;
    assign act_dp_nxt  = frame_start ? (load ? dp_in : pend_dp) : act_dp;

    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (act_val_nxt[4*i +: 4] == 4'd0);
            lz_mask[i] = all_zero;
        end
    end

    always_comb begin
        code   = act_val_nxt[3:0];
        lz_hit = 1'b0;
        dp_bit = act_dp_nxt[0];
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                code   = act_val_nxt[4*i +: 4];
                lz_hit = lz_mask[i];
                dp_bit = act_dp_nxt[i];
            end
        end
        seg_nxt = seg_lut(code);
        if ((HEX_EN == 0) && (code > 4'd9)) seg_nxt = 7'b1111111;
        if ((LZ_SUPPRESS != 0) && lz_hit)   seg_nxt = 7'b1111111;
        an_nxt = '1;
        if (32'(pre) >= DEAD_CYC) an_nxt[idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            act_val <= act_val_nxt;
            act_dp  <= act_dp_nxt;
            if (!enable) begin
                pre        <= '0;
                idx        <= '0;
                seg        <= 7'b1111111;
                dp         <= 1'b1;
                an         <= '1;
                frame_tick <= 1'b0;
            end else begin
                seg        <= seg_nxt;
                dp         <= ~dp_bit;
                an         <= an_nxt;
                frame_tick <= frame_start;
                if (pre == PRE_LAST) begin
                    pre <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: a cycle model feeds a scoreboard queue, plus directed frame captures.
module tb_seven_seg_scan_driver;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int DC = 1;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    localparam logic [6:0] BLK = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0] dp_in = '0;
    logic [6:0] seg0, seg1;
    logic dp0, dp1, ft0, ft1;
    logic [3:0] an0, an1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.N_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .HEX_EN(1), .LZ_SUPPRESS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in), .load(load),
        .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0));

    seven_seg_scan_driver #(.N_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .HEX_EN(0), .LZ_SUPPRESS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in), .load(load),
        .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit hex, input bit lz);
        logic [3:0] c;
        bit lead;
        c = v[4*d +: 4];
        lead = 1'b1;
        for (int k = d; k < ND; k++) if (v[4*k +: 4] != 4'd0) lead = 1'b0;
        if (lz && d > 0 && lead) return BLK;
        if (!hex && c > 4'd9) return BLK;
        return SEG_TAB[c];
    endfunction

    // Cycle model: m_t counts cycles since the frame start; expectations are queued per edge.
    typedef struct {
        logic [3:0] an;
        logic [6:0] s0;
        logic [6:0] s1;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t q[$];
    int m_t = 0;
    logic [19:0] m_pend = '0, m_act = '0;

    always @(posedge clk) begin
        exp_t e;
        int dig;
        if (rst_n !== 1'b1) begin
            m_t = 0;
            m_pend = '0;
            m_act = '0;
            q.delete();
        end else begin
            if (!enable) begin
                e = '{an: 4'hF, s0: BLK, s1: BLK, dp: 1'b1, ft: 1'b0};
                m_t = 0;
            end else begin
                if (m_t == 0) m_act = load ? {value, dp_in} : m_pend;
                dig = (m_t / SD) % ND;
                e.ft = (m_t == 0);
                e.an = 4'hF;
                if ((m_t % SD) >= DC) e.an[dig] = 1'b0;
                e.s0 = exp_seg(m_act[19:4], dig, 1'b1, 1'b1);
                e.s1 = exp_seg(m_act[19:4], dig, 1'b0, 1'b0);
                e.dp = ~m_act[dig];
                m_t = (m_t + 1) % (SD * ND);
            end
            if (load) m_pend = {value, dp_in};
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            chk("sb_an", 16'(an0), 16'(e.an));
            chk("sb_an1", 16'(an1), 16'(e.an));
            chk("sb_seg0", 16'(seg0), 16'(e.s0));
            chk("sb_seg1", 16'(seg1), 16'(e.s1));
            chk("sb_dp", 16'(dp0), 16'(e.dp));
            chk("sb_ft", 16'(ft0), 16'(e.ft));
        end
    end

    logic [3:0] cap_an [16];
    logic [6:0] cap_s0 [ND];
    logic [6:0] cap_s1 [ND];
    logic       cap_dp [ND];

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (ft0 !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("frame_tick_seen", 16'(ft0), 16'd1);
    endtask

    task automatic capture_frame();
        wait_tick();
        for (int off = 0; off < 16; off++) begin
            if (off > 0) @(negedge clk);
            cap_an[off] = an0;
            if (off % 4 == 2) begin
                cap_s0[off/4] = seg0;
                cap_s1[off/4] = seg1;
                cap_dp[off/4] = dp0;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(posedge clk); #1;
        value = v; dp_in = d; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_an", 16'(an0), 16'hF);
        chk("rst_seg", 16'(seg0), 16'(BLK));
        chk("rst_dp", 16'(dp0), 16'd1);
        chk("rst_ft", 16'(ft0), 16'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1234: enable and load together, so the first frame already shows it
        @(posedge clk); #1;
        enable = 1'b1; value = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        capture_frame();
        chk("1234_d0", 16'(cap_s0[0]), 16'(7'b1001100));
        chk("1234_d1", 16'(cap_s0[1]), 16'(7'b0000110));
        chk("1234_d2", 16'(cap_s0[2]), 16'(7'b0010010));
        chk("1234_d3", 16'(cap_s0[3]), 16'(7'b1001111));
        chk("an_dead0", 16'(cap_an[0]), 16'hF);
        chk("an_lit0", 16'(cap_an[2]), 16'hE);
        chk("an_dead1", 16'(cap_an[4]), 16'hF);
        chk("an_lit1", 16'(cap_an[6]), 16'hD);
        chk("an_lit2", 16'(cap_an[10]), 16'hB);
        chk("an_lit3", 16'(cap_an[14]), 16'h7);
        wait_tick();
        n = 0;
        do begin @(negedge clk); n++; end while (ft0 !== 1'b1 && n < 64);
        chk("frame_period", 16'(n), 16'd16);

        // leading zeros and decimal point
        do_load(16'h0007, 4'b0100);
        wait_tick();
        capture_frame();
        chk("lz7_d0", 16'(cap_s0[0]), 16'(7'b0001111));
        chk("lz7_d1", 16'(cap_s0[1]), 16'(BLK));
        chk("lz7_d2", 16'(cap_s0[2]), 16'(BLK));
        chk("lz7_d3", 16'(cap_s0[3]), 16'(BLK));
        chk("lz7_dp2", 16'(cap_dp[2]), 16'd0);
        chk("lz7_dp1", 16'(cap_dp[1]), 16'd1);
        chk("nolz7_d2", 16'(cap_s1[2]), 16'(7'b0000001));

        do_load(16'h0000, 4'b0000);
        wait_tick();
        capture_frame();
        chk("lz0_d0", 16'(cap_s0[0]), 16'(7'b0000001));
        chk("lz0_d1", 16'(cap_s0[1]), 16'(BLK));
        chk("nolz0_d3", 16'(cap_s1[3]), 16'(7'b0000001));

        do_load(16'hFA90, 4'b0000);
        wait_tick();
        capture_frame();
        chk("nohex_d3", 16'(cap_s1[3]), 16'(BLK));
        chk("nohex_d2", 16'(cap_s1[2]), 16'(BLK));
        chk("nohex_d1", 16'(cap_s1[1]), 16'(7'b0000100));
        chk("nohex_d0", 16'(cap_s1[0]), 16'(7'b0000001));
        chk("hex_d3", 16'(cap_s0[3]), 16'(7'b0111000));
        chk("hex_d2", 16'(cap_s0[2]), 16'(7'b0001000));

        // mid-frame load must not disturb the frame in progress
        wait_tick();
        repeat (5) @(negedge clk);
        do_load(16'h5555, 4'b0000);
        repeat (4) @(negedge clk);
        chk("mid_old_d2", 16'(seg0), 16'(7'b0001000));
        repeat (4) @(negedge clk);
        chk("mid_old_d3", 16'(seg0), 16'(7'b0111000));
        capture_frame();
        for (int d = 0; d < ND; d++) chk("mid_new", 16'(cap_s0[d]), 16'(7'b0100100));

        // load during the internal frame-start cycle (one cycle before frame_tick reaches the pin)
        repeat (15) @(negedge clk);
        @(posedge clk); #1;
        value = 16'h9999; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        capture_frame();
        for (int d = 0; d < ND; d++) chk("bypass9", 16'(cap_s0[d]), 16'(7'b0000100));

        // drop enable mid-slot, load while disabled, then restart
        repeat (6) @(negedge clk);
        @(posedge clk); #1 enable = 1'b0;
        @(negedge clk);
        chk("dis_lag_an", 16'(an0), 16'hD);
        @(negedge clk);
        chk("dis_an", 16'(an0), 16'hF);
        chk("dis_seg", 16'(seg0), 16'(BLK));
        chk("dis_dp", 16'(dp0), 16'd1);
        chk("dis_ft", 16'(ft0), 16'd0);
        do_load(16'h0021, 4'b0000);
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        chk("reen_lag_ft", 16'(ft0), 16'd0);
        @(negedge clk);
        chk("reen_ft", 16'(ft0), 16'd1);
        chk("reen_dead", 16'(an0), 16'hF);
        repeat (2) @(negedge clk);
        chk("reen_an", 16'(an0), 16'hE);
        chk("reen_seg", 16'(seg0), 16'(7'b1001111));

        // asynchronous reset between edges
        @(posedge clk); #1;
        chk("pre_rst_an", 16'(an0), 16'hE);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_an", 16'(an0), 16'hF);
        chk("arst_seg", 16'(seg0), 16'(BLK));
        chk("arst_dp", 16'(dp0), 16'd1);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_an", 16'(an0), 16'hF);
        chk("post_rst_seg", 16'(seg0), 16'(BLK));
        @(posedge clk); #1 enable = 1'b1;
        capture_frame();
        chk("post_rst_dead", 16'(cap_an[0]), 16'hF);
        chk("post_rst_d0", 16'(cap_s0[0]), 16'(7'b0000001));
        chk("post_rst_d1", 16'(cap_s0[1]), 16'(BLK));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
